// File: rtl/match_ctl.sv
// match_ctl: two-player match sequencer for a paddle game.
// Drives serve/rally/point/game-over sequencing, scores, winner and the
// point sound request. Every output comes from a flop.
// Optional feature: define MATCH_CTL_PAUSE_EN to add a pause state that
// toggles in and out of RALLY on pause-button presses.
module match_ctl #(
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       endframe,
  input  logic       start,
  input  logic       pause,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       game_reset,
  output logic       play,
  output logic       serve_dir,
  output logic [3:0] score_ply1,
  output logic [3:0] score_ply2,
  output logic [1:0] winner,
  output logic       snd_req
);

  // Frame counters compare against "last" values so that the state change
  // happens on the same edge where the count reaches the target.
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] POINT_LAST = 8'(POINT_FRAMES - 1);
  localparam logic [3:0] WIN_VAL    = 4'(WIN_SCORE);
  localparam logic [3:0] SCORE_MAX  = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_RALLY = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
`ifdef MATCH_CTL_PAUSE_EN
    ,
    ST_PAUSE = 3'd5
`endif
  } state_t;

  // Saturating score increment: a score at 15 stays at 15.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    logic [3:0] r;
    if (v == SCORE_MAX) begin
      r = v;
    end else begin
      r = v + 4'd1;
    end
    return r;
  endfunction

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] score1_q, score1_d;
  logic [3:0] score2_q, score2_d;
  logic [1:0] winner_q, winner_d;
  logic       serve_dir_q, serve_dir_d;
  logic       snd_req_q, snd_req_d;
  logic       play_q, play_d;
  logic       game_reset_q, game_reset_d;
  logic       start_prev_q, start_prev_d;
  logic       start_press_s;
  logic       pause_press_s;

`ifdef MATCH_CTL_PAUSE_EN
  logic       pause_prev_q, pause_prev_d;
`else
  logic       unused_pause_s;
`endif

  // Rising-edge detection on the button levels.
  always_comb begin
    start_prev_d  = start;
    start_press_s = start & ~start_prev_q;
`ifdef MATCH_CTL_PAUSE_EN
    pause_prev_d  = pause;
    pause_press_s = pause & ~pause_prev_q;
`else
    pause_press_s = 1'b0;
`endif
  end

`ifndef MATCH_CTL_PAUSE_EN
  // The pause button has no function in this build.
  assign unused_pause_s = pause ^ pause_press_s;
`endif

  // Next-state, score and output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    score1_d    = score1_q;
    score2_d    = score2_q;
    winner_d    = winner_q;
    serve_dir_d = serve_dir_q;
    snd_req_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_press_s) begin
          score1_d = 4'd0;
          score2_d = 4'd0;
          winner_d = 2'b00;
          cnt_d    = 8'd0;
          state_d  = ST_SERVE;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SERVE: begin
        if (endframe) begin
          if (cnt_q == SERVE_LAST) begin
            cnt_d   = 8'd0;
            state_d = ST_RALLY;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end

      ST_RALLY: begin
        if (miss_left && miss_right) begin
          // Let: replay the serve with nothing scored.
          cnt_d   = 8'd0;
          state_d = ST_SERVE;
        end else if (miss_left) begin
          score2_d    = sat_inc(score2_q);
          snd_req_d   = (score2_q != SCORE_MAX);
          serve_dir_d = 1'b0;
          cnt_d       = 8'd0;
          state_d     = ST_POINT;
        end else if (miss_right) begin
          score1_d    = sat_inc(score1_q);
          snd_req_d   = (score1_q != SCORE_MAX);
          serve_dir_d = 1'b1;
          cnt_d       = 8'd0;
          state_d     = ST_POINT;
        end else if (pause_press_s) begin
`ifdef MATCH_CTL_PAUSE_EN
          state_d = ST_PAUSE;
`else
          state_d = ST_RALLY;
`endif
        end else begin
          state_d = ST_RALLY;
        end
      end

      ST_POINT: begin
        if (endframe) begin
          if (cnt_q == POINT_LAST) begin
            cnt_d = 8'd0;
            if (score1_q == WIN_VAL) begin
              winner_d = 2'b01;
              state_d  = ST_OVER;
            end else if (score2_q == WIN_VAL) begin
              winner_d = 2'b10;
              state_d  = ST_OVER;
            end else begin
              state_d = ST_SERVE;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end

      ST_OVER: begin
        if (start_press_s) begin
          score1_d = 4'd0;
          score2_d = 4'd0;
          winner_d = 2'b00;
          cnt_d    = 8'd0;
          state_d  = ST_SERVE;
        end else begin
          state_d = ST_OVER;
        end
      end

`ifdef MATCH_CTL_PAUSE_EN
      ST_PAUSE: begin
        if (pause_press_s) begin
          state_d = ST_RALLY;
        end else begin
          state_d = ST_PAUSE;
        end
      end
`endif

      default: begin
        cnt_d   = 8'd0;
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they change on the same
    // edge as the state itself.
    play_d       = (state_d == ST_RALLY);
    game_reset_d = (state_d == ST_IDLE) || (state_d == ST_SERVE) ||
                   (state_d == ST_OVER);
  end

  // State, counter, score and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 8'd0;
      score1_q     <= 4'd0;
      score2_q     <= 4'd0;
      winner_q     <= 2'b00;
      serve_dir_q  <= 1'b0;
      snd_req_q    <= 1'b0;
      play_q       <= 1'b0;
      game_reset_q <= 1'b1;
      start_prev_q <= 1'b0;
`ifdef MATCH_CTL_PAUSE_EN
      pause_prev_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      score1_q     <= score1_d;
      score2_q     <= score2_d;
      winner_q     <= winner_d;
      serve_dir_q  <= serve_dir_d;
      snd_req_q    <= snd_req_d;
      play_q       <= play_d;
      game_reset_q <= game_reset_d;
      start_prev_q <= start_prev_d;
`ifdef MATCH_CTL_PAUSE_EN
      pause_prev_q <= pause_prev_d;
`endif
    end
  end

  assign game_reset = game_reset_q;
  assign play       = play_q;
  assign serve_dir  = serve_dir_q;
  assign score_ply1 = score1_q;
  assign score_ply2 = score2_q;
  assign winner     = winner_q;
  assign snd_req    = snd_req_q;

endmodule

// File: tb/tb_match_ctl.sv
// Directed testbench for match_ctl with default parameters
// (WIN_SCORE=9, SERVE_FRAMES=60, POINT_FRAMES=90).
module tb_match_ctl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       endframe = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       miss_left = 1'b0;
  logic       miss_right = 1'b0;
  logic       game_reset, play, serve_dir, snd_req;
  logic [3:0] score_ply1, score_ply2;
  logic [1:0] winner;

  int pass_cnt = 0;
  int total_cnt = 0;

  match_ctl dut (
    .clk(clk), .reset(reset), .endframe(endframe), .start(start),
    .pause(pause), .miss_left(miss_left), .miss_right(miss_right),
    .game_reset(game_reset), .play(play), .serve_dir(serve_dir),
    .score_ply1(score_ply1), .score_ply2(score_ply2), .winner(winner),
    .snd_req(snd_req)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs set afterwards are sampled at the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      endframe = 1'b1;
      step();
    end
    endframe = 1'b0;
  endtask

  task automatic press_start();
    start = 1'b1; step(); start = 1'b0; step();
  endtask

  task automatic score_point(input logic left);
    if (left) miss_left = 1'b1; else miss_right = 1'b1;
    step();
    miss_left = 1'b0; miss_right = 1'b0;
    frames(90);
  endtask

  task automatic test_reset();
    reset = 1'b1; step(); step(); reset = 1'b0;
    total_cnt++; if (game_reset !== 1'b1) $display("FAIL rst_game_reset got=%b exp=1", game_reset); else pass_cnt++;
    total_cnt++; if (play !== 1'b0) $display("FAIL rst_play got=%b exp=0", play); else pass_cnt++;
    total_cnt++; if ({score_ply1, score_ply2, winner} !== 10'd0) $display("FAIL rst_scores got=%0d:%0d w=%b exp=0:0 w=00", score_ply1, score_ply2, winner); else pass_cnt++;
    total_cnt++; if ({serve_dir, snd_req} !== 2'b00) $display("FAIL rst_dir_snd got=%b%b exp=00", serve_dir, snd_req); else pass_cnt++;
    // IDLE ignores frames and misses
    frames(3); miss_left = 1'b1; step(); miss_left = 1'b0; step();
    total_cnt++; if ({game_reset, play, score_ply2} !== 6'b100000) $display("FAIL idle_hold got gr=%b play=%b s2=%0d exp gr=1 play=0 s2=0", game_reset, play, score_ply2); else pass_cnt++;
  endtask

  task automatic test_serve();
    // Start press coincides with an endframe that must not be counted.
    start = 1'b1; endframe = 1'b1; step(); start = 1'b0; endframe = 1'b0;
    total_cnt++; if ({game_reset, play} !== 2'b10) $display("FAIL serve_entry got gr=%b play=%b exp gr=1 play=0", game_reset, play); else pass_cnt++;
    miss_left = 1'b1; step(); miss_left = 1'b0;
    total_cnt++; if ({score_ply2, snd_req} !== 5'd0) $display("FAIL serve_miss_ignored got s2=%0d snd=%b exp s2=0 snd=0", score_ply2, snd_req); else pass_cnt++;
    frames(59);
    total_cnt++; if (play !== 1'b0) $display("FAIL serve_59 got play=%b exp=0", play); else pass_cnt++;
    frames(1);
    total_cnt++; if ({play, game_reset} !== 2'b10) $display("FAIL serve_60 got play=%b gr=%b exp play=1 gr=0", play, game_reset); else pass_cnt++;
  endtask

  task automatic test_point();
    miss_right = 1'b1; step(); miss_right = 1'b0;
    total_cnt++; if (score_ply1 !== 4'd1 || score_ply2 !== 4'd0) $display("FAIL point_score got=%0d:%0d exp=1:0", score_ply1, score_ply2); else pass_cnt++;
    total_cnt++; if ({serve_dir, snd_req, play, game_reset} !== 4'b1100) $display("FAIL point_outs got dir=%b snd=%b play=%b gr=%b exp 1 1 0 0", serve_dir, snd_req, play, game_reset); else pass_cnt++;
    step();
    total_cnt++; if (snd_req !== 1'b0) $display("FAIL point_snd_one_cycle got=%b exp=0", snd_req); else pass_cnt++;
    // start ignored in POINT, misses ignored in POINT
    start = 1'b1; miss_right = 1'b1; step(); start = 1'b0; miss_right = 1'b0; step();
    frames(89);
    total_cnt++; if ({game_reset, play, score_ply1} !== 6'b000001) $display("FAIL point_89 got gr=%b play=%b s1=%0d exp gr=0 play=0 s1=1", game_reset, play, score_ply1); else pass_cnt++;
    frames(1);
    total_cnt++; if ({game_reset, play} !== 2'b10) $display("FAIL point_90_serve got gr=%b play=%b exp gr=1 play=0", game_reset, play); else pass_cnt++;
    frames(60);
    total_cnt++; if (play !== 1'b1) $display("FAIL point_back_rally got=%b exp=1", play); else pass_cnt++;
  endtask

  task automatic test_let();
    miss_left = 1'b1; miss_right = 1'b1; step(); miss_left = 1'b0; miss_right = 1'b0;
    total_cnt++; if (score_ply1 !== 4'd1 || score_ply2 !== 4'd0 || snd_req !== 1'b0) $display("FAIL let_score got=%0d:%0d snd=%b exp=1:0 snd=0", score_ply1, score_ply2, snd_req); else pass_cnt++;
    total_cnt++; if ({serve_dir, game_reset, play} !== 3'b110) $display("FAIL let_serve got dir=%b gr=%b play=%b exp 1 1 0", serve_dir, game_reset, play); else pass_cnt++;
    frames(60);
    total_cnt++; if (play !== 1'b1) $display("FAIL let_rally got=%b exp=1", play); else pass_cnt++;
  endtask

  task automatic test_win();
    for (int i = 0; i < 8; i++) begin
      score_point(1'b1);
      frames(60);
    end
    miss_left = 1'b1; step(); miss_left = 1'b0;
    frames(89);
    total_cnt++; if (winner !== 2'b00 || score_ply2 !== 4'd9) $display("FAIL win_pre got w=%b s2=%0d exp w=00 s2=9", winner, score_ply2); else pass_cnt++;
    frames(1);
    total_cnt++; if ({winner, game_reset, play} !== 4'b1010) $display("FAIL win_over got w=%b gr=%b play=%b exp w=10 gr=1 play=0", winner, game_reset, play); else pass_cnt++;
    total_cnt++; if (score_ply1 !== 4'd1 || serve_dir !== 1'b0) $display("FAIL win_state got s1=%0d dir=%b exp s1=1 dir=0", score_ply1, serve_dir); else pass_cnt++;
    frames(200);
    total_cnt++; if (winner !== 2'b10) $display("FAIL win_hold got=%b exp=10", winner); else pass_cnt++;
    press_start();
    total_cnt++; if ({score_ply1, score_ply2, winner, game_reset} !== 11'b00000000001) $display("FAIL win_restart got=%0d:%0d w=%b gr=%b exp=0:0 w=00 gr=1", score_ply1, score_ply2, winner, game_reset); else pass_cnt++;
    frames(60);
    total_cnt++; if (play !== 1'b1) $display("FAIL win_restart_rally got=%b exp=1", play); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    score_point(1'b0); frames(60);
    score_point(1'b0); frames(60);
    score_point(1'b0); frames(60);
    score_point(1'b1); frames(60);
    score_point(1'b1); frames(60);
    total_cnt++; if (score_ply1 !== 4'd3 || score_ply2 !== 4'd2 || play !== 1'b1) $display("FAIL mid_pre got=%0d:%0d play=%b exp=3:2 play=1", score_ply1, score_ply2, play); else pass_cnt++;
    // reset beats a simultaneous miss and start
    reset = 1'b1; miss_right = 1'b1; start = 1'b1; step();
    reset = 1'b0; miss_right = 1'b0; start = 1'b0;
    total_cnt++; if ({score_ply1, score_ply2, play, game_reset, snd_req} !== 11'b00000000010) $display("FAIL mid_reset got=%0d:%0d play=%b gr=%b snd=%b exp=0:0 0 1 0", score_ply1, score_ply2, play, game_reset, snd_req); else pass_cnt++;
    frames(70);
    total_cnt++; if ({play, game_reset} !== 2'b01) $display("FAIL mid_idle got play=%b gr=%b exp play=0 gr=1", play, game_reset); else pass_cnt++;
  endtask

  task automatic test_pause();
    press_start(); frames(60);
    pause = 1'b1; step(); pause = 1'b0;
`ifdef MATCH_CTL_PAUSE_EN
    total_cnt++; if ({play, game_reset} !== 2'b00) $display("FAIL pause_enter got play=%b gr=%b exp 0 0", play, game_reset); else pass_cnt++;
    miss_left = 1'b1; step(); miss_left = 1'b0;
    total_cnt++; if (score_ply2 !== 4'd0 || snd_req !== 1'b0) $display("FAIL pause_miss got s2=%0d snd=%b exp 0 0", score_ply2, snd_req); else pass_cnt++;
    pause = 1'b1; step(); pause = 1'b0;
    total_cnt++; if (play !== 1'b1) $display("FAIL pause_exit got=%b exp=1", play); else pass_cnt++;
`else
    total_cnt++; if (play !== 1'b1) $display("FAIL pause_ignored got=%b exp=1", play); else pass_cnt++;
    miss_left = 1'b1; step(); miss_left = 1'b0;
    total_cnt++; if (score_ply2 !== 4'd1 || snd_req !== 1'b1) $display("FAIL pause_miss_live got s2=%0d snd=%b exp 1 1", score_ply2, snd_req); else pass_cnt++;
`endif
  endtask

  initial begin
    test_reset();
    test_serve();
    test_point();
    test_let();
    test_win();
    test_reset_mid();
    test_pause();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
